pipelined_pc_unit: RTL and testbench



---
 rtl/pipeline_defs_pkg.sv | 21 ++
 rtl/pipelined_pc_unit_redirect_sel.sv | 83 ++++++++
 rtl/pipelined_pc_unit.sv | 103 ++++++++++
 tb/tb_pipelined_pc_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs_pkg.sv
// Shared pipeline definitions: redirect-kind encoding and default fetch constants.
// Used by the PC unit and the hazard unit so both agree on how redirects rank.
package pipeline_defs;

    // Redirect classes; the numeric value doubles as the priority rank (EXC > BR).
    typedef enum logic {
        KIND_BR  = 1'b0,
        KIND_EXC = 1'b1
    } redirect_kind_t;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam int          DEFAULT_INC      = 4;
    localparam int          DEFAULT_ALIGN    = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // True when a redirect of kind 'a' is allowed to replace one of kind 'b'.
    function automatic logic kind_ranks_ge(input redirect_kind_t a, input redirect_kind_t b);
        return (a >= b);
    endfunction

endpackage

// File: rtl/pipelined_pc_unit_redirect_sel.sv
// Combinational redirect selector for the fetch PC.
// Picks the highest-ranked of {live EXC, pending EXC, live BR, pending BR},
// decides whether PC loads a target, advances sequentially or holds, and
// whether the pending slot is cleared or captures a live redirect.
module pc_redirect_sel
    import pipeline_defs::*;
#(
    parameter int WIDTH               = DEFAULT_WIDTH,
    parameter bit EXC_OVERRIDES_STALL = 1'b1
) (
    input  logic                 stall,
    input  logic                 br_redirect,
    input  logic [WIDTH-1:0]     br_target,
    input  logic                 exc_redirect,
    input  logic [WIDTH-1:0]     exc_target,
    input  logic                 pend_v,
    input  redirect_kind_t       pend_kind,
    input  logic [WIDTH-1:0]     pend_pc,
    output logic                 load_target,
    output logic [WIDTH-1:0]     target,
    output logic                 advance,
    output logic                 clear_pend,
    output logic                 capture,
    output redirect_kind_t       capture_kind,
    output logic [WIDTH-1:0]     capture_target
);

    logic pend_exc;
    logic pend_br;
    logic cand_v;
    logic exc_cand;
    logic live_v;

    assign pend_exc = pend_v && (pend_kind == KIND_EXC);
    assign pend_br  = pend_v && (pend_kind == KIND_BR);
    assign live_v   = exc_redirect || br_redirect;

    // Priority candidate: live beats pending inside a class, EXC beats BR.
    always_comb begin
        cand_v   = 1'b1;
        exc_cand = 1'b0;
        target   = '0;
        if (exc_redirect) begin
            target   = exc_target;
            exc_cand = 1'b1;
        end else if (pend_exc) begin
            target   = pend_pc;
            exc_cand = 1'b1;
        end else if (br_redirect) begin
            target   = br_target;
        end else if (pend_br) begin
            target   = pend_pc;
        end else begin
            cand_v   = 1'b0;
        end
    end

    // Live redirect that would be captured while stalled; EXC wins a same-cycle tie.
    always_comb begin
        capture_kind   = exc_redirect ? KIND_EXC : KIND_BR;
        capture_target = exc_redirect ? exc_target : br_target;
    end

    // Action decode: run, exception breaking through a stall, or hold-and-capture.
    always_comb begin
        load_target = 1'b0;
        advance     = 1'b0;
        clear_pend  = 1'b0;
        capture     = 1'b0;
        if (!stall) begin
            load_target = cand_v;
            advance     = !cand_v;
            clear_pend  = 1'b1;
        end else if (EXC_OVERRIDES_STALL && exc_cand) begin
            load_target = 1'b1;
            clear_pend  = 1'b1;
        end else if (live_v) begin
            // A live BR must never displace a pending EXC.
            capture = !pend_v || kind_ranks_ge(capture_kind, pend_kind);
        end
    end

endmodule

// File: rtl/pipelined_pc_unit.sv
// IF-stage fetch-address register with sequential increment, prioritised
// branch/exception redirects and a one-entry pending slot that holds a
// redirect seen during a stall until the stall releases.
module pipelined_pc_unit
    import pipeline_defs::*;
#(
    parameter int               WIDTH               = DEFAULT_WIDTH,
    parameter int               INC                 = DEFAULT_INC,
    parameter int               ALIGN_BITS          = DEFAULT_ALIGN,
    parameter logic [WIDTH-1:0] RESET_PC            = WIDTH'(DEFAULT_RESET_PC),
    parameter bit               EXC_OVERRIDES_STALL = 1'b1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Stall,
    input  logic             Br_Redirect,
    input  logic [WIDTH-1:0] Br_Target,
    input  logic             Exc_Redirect,
    input  logic [WIDTH-1:0] Exc_Target,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_Plus,
    output logic             Redirect_Pending,
    output logic             Misalign
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pc_reg;
    logic             pend_v_reg;
    redirect_kind_t   pend_kind_reg;
    logic [WIDTH-1:0] pend_pc_reg;
    logic             misalign_reg;

    logic             load_target;
    logic [WIDTH-1:0] target;
    logic             advance;
    logic             clear_pend;
    logic             capture;
    redirect_kind_t   capture_kind;
    logic [WIDTH-1:0] capture_target;

    pc_redirect_sel #(
        .WIDTH               (WIDTH),
        .EXC_OVERRIDES_STALL (EXC_OVERRIDES_STALL)
    ) u_sel (
        .stall          (Stall),
        .br_redirect    (Br_Redirect),
        .br_target      (Br_Target),
        .exc_redirect   (Exc_Redirect),
        .exc_target     (Exc_Target),
        .pend_v         (pend_v_reg),
        .pend_kind      (pend_kind_reg),
        .pend_pc        (pend_pc_reg),
        .load_target    (load_target),
        .target         (target),
        .advance        (advance),
        .clear_pend     (clear_pend),
        .capture        (capture),
        .capture_kind   (capture_kind),
        .capture_target (capture_target)
    );

    // PC register: load redirect target, step sequentially, or hold under stall.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_reg <= RESET_PC;
        end else if (load_target) begin
            pc_reg <= target;
        end else if (advance) begin
            pc_reg <= PC_Plus;
        end
    end

    // Pending-redirect slot: cleared whenever PC moves, filled by ranked capture.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pend_v_reg    <= 1'b0;
            pend_kind_reg <= KIND_BR;
            pend_pc_reg   <= '0;
        end else if (clear_pend) begin
            pend_v_reg    <= 1'b0;
        end else if (capture) begin
            pend_v_reg    <= 1'b1;
            pend_kind_reg <= capture_kind;
            pend_pc_reg   <= capture_target;
        end
    end

    // Misalign pulse: flags the cycle after a target with nonzero low bits is loaded.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= load_target && ((target & ALIGN_MASK) != '0);
        end
    end

    assign PC               = pc_reg;
    assign PC_Plus          = pc_reg + WIDTH'(INC);
    assign Redirect_Pending = pend_v_reg;
    assign Misalign         = misalign_reg;

endmodule

// File: tb/tb_pipelined_pc_unit.sv
// Self-checking bench for pipelined_pc_unit. Two instances share stimulus:
// u_ovr (exception breaks through stall) and u_hold (exception waits like a branch).
module tb_pipelined_pc_unit;

    logic        clk = 1'b0;
    logic        clrn;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] et;

    logic [31:0] pc1, pp1, pc0, pp0;
    logic        rp1, ms1, rp0, ms0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pipelined_pc_unit #(.EXC_OVERRIDES_STALL(1'b1)) u_ovr (
        .Clk(clk), .Clrn(clrn), .Stall(stall), .Br_Redirect(br), .Br_Target(bt),
        .Exc_Redirect(exc), .Exc_Target(et), .PC(pc1), .PC_Plus(pp1),
        .Redirect_Pending(rp1), .Misalign(ms1));

    pipelined_pc_unit #(.EXC_OVERRIDES_STALL(1'b0)) u_hold (
        .Clk(clk), .Clrn(clrn), .Stall(stall), .Br_Redirect(br), .Br_Target(bt),
        .Exc_Redirect(exc), .Exc_Target(et), .PC(pc0), .PC_Plus(pp0),
        .Redirect_Pending(rp0), .Misalign(ms0));

    // Reference model: architectural view of the unit (PC, one pending slot, misalign flag).
    typedef struct {
        logic [31:0] pc;
        bit          pend;
        int          pend_rank;   // 1 = exception, 0 = branch
        logic [31:0] pend_pc;
        bit          mis;
    } mstate_t;

    mstate_t m1, m0;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.pc = 32'h0; s.pend = 0; s.pend_rank = 0; s.pend_pc = 32'h0; s.mis = 0;
        return s;
    endfunction

    function automatic mstate_t model_step(mstate_t s, bit ovr, bit st, bit b, logic [31:0] btg,
                                           bit e, logic [31:0] etg);
        mstate_t n = s;
        int          best = -1;     // score: 3 live exc, 2 pending exc, 1 live br, 0 pending br
        logic [31:0] tgt  = 32'h0;
        if (s.pend && s.pend_rank == 0) begin best = 0; tgt = s.pend_pc; end
        if (b)                          begin best = 1; tgt = btg;       end
        if (s.pend && s.pend_rank == 1) begin best = 2; tgt = s.pend_pc; end
        if (e)                          begin best = 3; tgt = etg;       end
        n.mis = 0;
        if (!st || (ovr && best >= 2)) begin
            if (best >= 0) begin
                n.pc  = tgt;
                n.mis = (tgt % 4) != 0;
            end else begin
                n.pc = s.pc + 32'd4;
            end
            n.pend = 0;
        end else if (e || b) begin
            int lr = e ? 1 : 0;
            if (!s.pend || lr >= s.pend_rank) begin
                n.pend = 1; n.pend_rank = lr; n.pend_pc = e ? etg : btg;
            end
        end
        return n;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic drive(bit st, bit b, logic [31:0] btg, bit e, logic [31:0] etg);
        stall = st; br = b; bt = btg; exc = e; et = etg;
        @(posedge clk);
        m1 = model_step(m1, 1'b1, st, b, btg, e, etg);
        m0 = model_step(m0, 1'b0, st, b, btg, e, etg);
        #1;
    endtask

    task automatic reset_dut();
        stall = 0; br = 0; bt = 0; exc = 0; et = 0;
        clrn = 1'b0;
        @(negedge clk);
        m1 = model_reset(); m0 = model_reset();
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        stall = 0; br = 0; bt = 0; exc = 0; et = 0;
        clrn = 1'b0;
        #2;
        total++; if (pc1 !== 32'h0 || pc0 !== 32'h0) $display("FAIL reset_pc got %h/%h want 0", pc1, pc0); else pass_cnt++;
        total++; if (rp1 !== 1'b0 || rp0 !== 1'b0 || ms1 !== 1'b0 || ms0 !== 1'b0)
            $display("FAIL reset_flags got rp %b/%b mis %b/%b want 0", rp1, rp0, ms1, ms0); else pass_cnt++;
        @(negedge clk);
        m1 = model_reset(); m0 = model_reset();
        clrn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0);
            exp_pc = 32'(4 * i);
            total++; if (pc1 !== exp_pc || pc0 !== exp_pc) $display("FAIL seq_pc%0d got %h/%h want %h", i, pc1, pc0, exp_pc); else pass_cnt++;
            $display("seq cycle %0d pc=%h", i, pc1);
        end
        total++; if (pp1 !== 32'h10 || pp0 !== 32'h10) $display("FAIL seq_pc_plus got %h/%h want 00000010", pp1, pp0); else pass_cnt++;
    endtask

    task automatic test_stall_branch();
        reset_dut();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++; if (pc1 !== 32'h8 || pc0 !== 32'h8 || rp1 !== 1'b1 || rp0 !== 1'b1)
                $display("FAIL stall_hold%0d got pc %h/%h rp %b/%b want 8/1", i, pc1, pc0, rp1, rp0); else pass_cnt++;
            if (i < 2) drive(1, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h100 || pc0 !== 32'h100 || rp1 !== 1'b0 || rp0 !== 1'b0)
            $display("FAIL stall_release got pc %h/%h rp %b/%b want 100/0", pc1, pc0, rp1, rp0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h104 || pc0 !== 32'h104) $display("FAIL stall_after got %h/%h want 104", pc1, pc0); else pass_cnt++;
        $display("stall/branch scenario pc=%h", pc1);
    endtask

    task automatic test_exc_override();
        reset_dut();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h80);
        total++; if (pc1 !== 32'h80 || rp1 !== 1'b0) $display("FAIL exc_ovr got pc %h rp %b want 80/0", pc1, rp1); else pass_cnt++;
        total++; if (pc0 !== 32'h4 || rp0 !== 1'b1) $display("FAIL exc_hold got pc %h rp %b want 4/1", pc0, rp0); else pass_cnt++;
        drive(1, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h80 || pc0 !== 32'h4 || rp0 !== 1'b1)
            $display("FAIL exc_stall2 got pc %h/%h rp %b want 80/4/1", pc1, pc0, rp0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h84 || pc0 !== 32'h80 || rp0 !== 1'b0)
            $display("FAIL exc_release got pc %h/%h rp %b want 84/80/0", pc1, pc0, rp0); else pass_cnt++;
        $display("exception override scenario pc=%h/%h", pc1, pc0);
    endtask

    task automatic test_priority();
        reset_dut();
        drive(0, 1, 32'h200, 1, 32'h80);
        total++; if (pc1 !== 32'h80 || pc0 !== 32'h80) $display("FAIL prio_same got %h/%h want 80", pc1, pc0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h80);
        drive(1, 1, 32'h200, 0, 0);
        total++; if (pc0 !== 32'h84 || rp0 !== 1'b1 || pc1 !== 32'h80 || rp1 !== 1'b1)
            $display("FAIL prio_stall got pc %h/%h rp %b/%b want 80/84 1/1", pc1, pc0, rp1, rp0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc0 !== 32'h80) $display("FAIL prio_pend_exc got %h want 80", pc0); else pass_cnt++;
        total++; if (pc1 !== 32'h200) $display("FAIL prio_pend_br got %h want 200", pc1); else pass_cnt++;
        $display("priority scenario pc=%h/%h", pc1, pc0);
    endtask

    task automatic test_reset_mid_pending();
        reset_dut();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 32'h300, 0, 0);
        total++; if (rp1 !== 1'b1 || rp0 !== 1'b1) $display("FAIL midrst_capture got rp %b/%b want 1", rp1, rp0); else pass_cnt++;
        #3 clrn = 1'b0;
        #1;
        total++; if (pc1 !== 32'h0 || pc0 !== 32'h0 || rp1 !== 1'b0 || rp0 !== 1'b0)
            $display("FAIL midrst_async got pc %h/%h rp %b/%b want 0/0", pc1, pc0, rp1, rp0); else pass_cnt++;
        m1 = model_reset(); m0 = model_reset();
        #1 clrn = 1'b1;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h4 || pc0 !== 32'h4) $display("FAIL midrst_after got %h/%h want 4", pc1, pc0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h8 || pc0 !== 32'h8) $display("FAIL midrst_no_stale got %h/%h want 8", pc1, pc0); else pass_cnt++;
        $display("reset mid-pending scenario pc=%h", pc1);
    endtask

    task automatic test_misalign_wrap();
        reset_dut();
        drive(0, 1, 32'h102, 0, 0);
        total++; if (pc1 !== 32'h102 || ms1 !== 1'b1 || ms0 !== 1'b1)
            $display("FAIL misalign_load got pc %h mis %b/%b want 102/1", pc1, ms1, ms0); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h106 || ms1 !== 1'b0 || ms0 !== 1'b0)
            $display("FAIL misalign_pulse got pc %h mis %b/%b want 106/0", pc1, ms1, ms0); else pass_cnt++;
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        total++; if (pc1 !== 32'hFFFF_FFFC || pp1 !== 32'h0 || ms1 !== 1'b0)
            $display("FAIL wrap_top got pc %h plus %h mis %b want fffffffc/0/0", pc1, pp1, ms1); else pass_cnt++;
        drive(0, 0, 0, 0, 0);
        total++; if (pc1 !== 32'h0 || pc0 !== 32'h0) $display("FAIL wrap_zero got %h/%h want 0", pc1, pc0); else pass_cnt++;
        $display("misalign/wrap scenario pc=%h", pc1);
    endtask

    task automatic test_random();
        logic [31:0] rb, re;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            rb = $urandom & 32'h0000_FFFC;
            re = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 9) == 0) rb[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) re[0] = 1'b1;
            if ($urandom_range(0, 39) == 0) rb = 32'hFFFF_FFF8;
            if ($urandom_range(0, 99) == 0) begin
                #3 clrn = 1'b0;
                #1 m1 = model_reset(); m0 = model_reset();
                #1 clrn = 1'b1;
            end
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rb,
                  $urandom_range(0, 7) == 0, re);
            total++; if (pc1 !== m1.pc || pp1 !== m1.pc + 32'd4 || rp1 !== m1.pend || ms1 !== m1.mis)
                $display("FAIL rand_ovr%0d got pc %h plus %h rp %b mis %b want %h %h %b %b",
                         i, pc1, pp1, rp1, ms1, m1.pc, m1.pc + 32'd4, m1.pend, m1.mis);
            else pass_cnt++;
            total++; if (pc0 !== m0.pc || pp0 !== m0.pc + 32'd4 || rp0 !== m0.pend || ms0 !== m0.mis)
                $display("FAIL rand_hold%0d got pc %h plus %h rp %b mis %b want %h %h %b %b",
                         i, pc0, pp0, rp0, ms0, m0.pc, m0.pc + 32'd4, m0.pend, m0.mis);
            else pass_cnt++;
            if (i % 100 == 0) $display("random cycle %0d pc=%h/%h", i, pc1, pc0);
        end
    endtask

    initial begin
        m1 = model_reset(); m0 = model_reset();
        test_reset();
        test_stall_branch();
        test_exc_override();
        test_priority();
        test_reset_mid_pending();
        test_misalign_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
